// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: iterative radix-2 shift-add multiplier and
// restoring divider sharing one {hi, lo} shift register, with a valid/ready request/response pair.
module muldiv_unit #(
  parameter int W     = 32,
  parameter int CNT_W = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] out
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [W-1:0]     ZERO_W   = {W{1'b0}};
  localparam logic [W-1:0]     ONES_W   = {W{1'b1}};
  localparam logic [W-1:0]     INT_MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] x);
    return ~x + {{(W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] x);
    return ~x + {{(2*W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [W-1:0] cond_neg_w(input logic [W-1:0] x, input logic n);
    return n ? neg_w(x) : x;
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       op_r;
  logic [W-1:0]     hi_r, lo_r, b_r, out_r;
  logic             a_neg_r, b_neg_r, prep_r;

  logic             is_div_s, in1_signed_s, in2_signed_s;
  logic             div_zero_s, div_ovf_s, special_s, accept_s;
  logic [W-1:0]     special_res_s;
  logic [W:0]       mul_sum_s, div_sh_s, div_diff_s;
  logic [2*W-1:0]   prod_s, prod_fix_s;
  logic             res_neg_s;
  logic [W-1:0]     result_s;

  assign req_ready  = (state_r == IDLE);
  assign resp_valid = (state_r == DONE);
  assign out        = out_r;

  assign is_div_s     = op[2];
  assign in1_signed_s = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign in2_signed_s = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign div_zero_s   = is_div_s && (in2 == ZERO_W);
  assign div_ovf_s    = ((op == OP_DIV) || (op == OP_REM)) && (in1 == INT_MIN) && (in2 == ONES_W);
  assign special_s    = div_zero_s || div_ovf_s;
  assign accept_s     = req_valid && (state_r == IDLE) && !flush;

  // Immediate result for divide-by-zero and signed overflow (op[1] selects the remainder ops).
  always_comb begin
    special_res_s = ZERO_W;
    if (div_zero_s) begin
      special_res_s = op[1] ? in1 : ONES_W;
    end else if (div_ovf_s) begin
      special_res_s = op[1] ? ZERO_W : in1;
    end else begin
      special_res_s = ZERO_W;
    end
  end

  // One shift-add or restoring-subtract step on the shared {hi, lo} register.
  always_comb begin
    mul_sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(W+1){1'b0}});
    div_sh_s   = {hi_r, lo_r[W-1]};
    div_diff_s = div_sh_s - {1'b0, b_r};
  end

  // Sign correction and high/low selection applied in FIX.
  always_comb begin
    prod_s     = {hi_r, lo_r};
    res_neg_s  = (op_r == OP_REM) ? a_neg_r : (a_neg_r ^ b_neg_r);
    prod_fix_s = res_neg_s ? neg_2w(prod_s) : prod_s;
    case (op_r)
      OP_MUL:                        result_s = prod_fix_s[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result_s = prod_fix_s[2*W-1:W];
      OP_DIV, OP_DIVU:               result_s = cond_neg_w(lo_r, res_neg_s);
      OP_REM, OP_REMU:               result_s = cond_neg_w(hi_r, res_neg_s);
      default:                       result_s = ZERO_W;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; flush overrides every other transition.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (flush) begin
          state_s = IDLE;
        end else if (req_valid) begin
          state_s = special_s ? DONE : RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (flush) begin
          state_s = IDLE;
        end else if (!prep_r && (cnt_r == CNT_LAST)) begin
          state_s = FIX;
        end else begin
          state_s = RUN;
        end
      end
      FIX: begin
        if (flush) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      DONE: begin
        if (flush) begin
          state_s = IDLE;
        end else if (resp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: operand capture, magnitude prep cycle, W iterations, result load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= CNT_ZERO;
      op_r    <= 3'd0;
      hi_r    <= ZERO_W;
      lo_r    <= ZERO_W;
      b_r     <= ZERO_W;
      out_r   <= ZERO_W;
      a_neg_r <= 1'b0;
      b_neg_r <= 1'b0;
      prep_r  <= 1'b0;
    end else if (flush) begin
      cnt_r  <= CNT_ZERO;
      prep_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r    <= op;
            a_neg_r <= in1_signed_s && in1[W-1];
            b_neg_r <= in2_signed_s && in2[W-1];
            hi_r    <= ZERO_W;
            cnt_r   <= CNT_ZERO;
            prep_r  <= 1'b1;
            // Divide keeps the dividend in lo; multiply keeps the multiplier in lo.
            if (is_div_s) begin
              lo_r <= in1;
              b_r  <= in2;
            end else begin
              lo_r <= in2;
              b_r  <= in1;
            end
            if (special_s) begin
              out_r <= special_res_s;
            end
          end
        end
        RUN: begin
          if (prep_r) begin
            prep_r <= 1'b0;
            if (op_r[2]) begin
              lo_r <= cond_neg_w(lo_r, a_neg_r);
              b_r  <= cond_neg_w(b_r, b_neg_r);
            end else begin
              lo_r <= cond_neg_w(lo_r, b_neg_r);
              b_r  <= cond_neg_w(b_r, a_neg_r);
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
            if (op_r[2]) begin
              if (!div_diff_s[W]) begin
                hi_r <= div_diff_s[W-1:0];
                lo_r <= {lo_r[W-2:0], 1'b1};
              end else begin
                hi_r <= div_sh_s[W-1:0];
                lo_r <= {lo_r[W-2:0], 1'b0};
              end
            end else begin
              hi_r <= mul_sum_s[W:1];
              lo_r <= {mul_sum_s[0], lo_r[W-1:1]};
            end
          end
        end
        FIX: begin
          out_r <= result_s;
        end
        DONE: begin
          out_r <= out_r;
        end
        default: begin
          out_r <= out_r;
        end
      endcase
    end
  end

endmodule
